board_char_store: RTL

- Source end of the character-pixel interface used by the board number overlay.
- Holds one 4-bit display code per board field, written by game logic.
- Answers (char_x, char_y, char_line) lookups with a 50-bit glyph line after a fixed 2-cycle latency.
- Sits between the game-state logic (writer) and the board character drawing stage (reader). Includes a board-clear sequencer for new games.

---
 rtl/board_char_pkg.sv | 48 ++++
 rtl/board_char_store_if.sv | 29 ++
 rtl/board_char_store_glyph_line_expand.sv | 37 +++
 rtl/board_char_store.sv | 111 +++++++++++
 4 files changed

// File: rtl/board_char_pkg.sv
// Shared types and the 5x5 font for the board number overlay.
package board_char_pkg;

    localparam int FONT_ROWS = 5;

    typedef enum logic [3:0] {
        CODE_EMPTY  = 4'd0,
        CODE_1      = 4'd1,
        CODE_2      = 4'd2,
        CODE_3      = 4'd3,
        CODE_4      = 4'd4,
        CODE_5      = 4'd5,
        CODE_6      = 4'd6,
        CODE_7      = 4'd7,
        CODE_8      = 4'd8,
        CODE_MINE   = 4'd9,
        CODE_FLAG   = 4'd10,
        CODE_HIDDEN = 4'd15
    } disp_code_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clear_state_t;

    // Glyphs are stored top row first; within a row bit 4 is the leftmost pixel.
    function automatic logic [FONT_ROWS-1:0] font_row(input disp_code_t code, input logic [2:0] row);
        logic [FONT_ROWS*FONT_ROWS-1:0] glyph;
        case (code)
            CODE_1:    glyph = 25'b00100_01100_00100_00100_01110;
            CODE_2:    glyph = 25'b01110_10001_00110_01000_11111;
            CODE_3:    glyph = 25'b11110_00001_01110_00001_11110;
            CODE_4:    glyph = 25'b10010_10010_11111_00010_00010;
            CODE_5:    glyph = 25'b11111_10000_11110_00001_11110;
            CODE_6:    glyph = 25'b01110_10000_11110_10001_01110;
            CODE_7:    glyph = 25'b11111_00001_00010_00100_00100;
            CODE_8:    glyph = 25'b01110_10001_01110_10001_01110;
            CODE_MINE: glyph = 25'b10101_01110_11111_01110_10101;
            CODE_FLAG: glyph = 25'b11100_11110_11100_10000_10000;
            default:   glyph = '0;
        endcase
        font_row = '0;
        if (int'(row) < FONT_ROWS) begin
            font_row = glyph[(FONT_ROWS - 1 - int'(row)) * FONT_ROWS +: FONT_ROWS];
        end
    endfunction

endpackage

// File: rtl/board_char_store_if.sv
// Writer, reader and clear signals between game logic, the store and the drawing stage.
interface board_char_store_if #(
    parameter int PIX_W = 50
);
    logic [4:0]       button_num;
    logic [4:0]       char_x;
    logic [4:0]       char_y;
    logic [5:0]       char_line;
    logic [PIX_W-1:0] char_pixels;
    logic             wr_en;
    logic [4:0]       wr_x;
    logic [4:0]       wr_y;
    logic [3:0]       wr_code;
    logic             wr_ready;
    logic             clear_req;
    logic             busy;

    modport master (
        output button_num, char_x, char_y, char_line,
        output wr_en, wr_x, wr_y, wr_code, clear_req,
        input  char_pixels, wr_ready, busy
    );

    modport slave (
        input  button_num, char_x, char_y, char_line,
        input  wr_en, wr_x, wr_y, wr_code, clear_req,
        output char_pixels, wr_ready, busy
    );
endinterface

// File: rtl/board_char_store_glyph_line_expand.sv
// Second read stage: font lookup and horizontal pixel replication into a registered glyph line.
module glyph_line_expand
    import board_char_pkg::*;
#(
    parameter  int GLYPH_SCALE = 10,
    localparam int PIX_W       = FONT_ROWS * GLYPH_SCALE
) (
    input  logic             clk,
    input  logic             rst,
    input  disp_code_t       code,
    input  logic [2:0]       row,
    input  logic             valid,
    output logic [PIX_W-1:0] char_pixels
);

    logic [FONT_ROWS-1:0] font_bits;
    logic [PIX_W-1:0]     pix_d;
    logic [PIX_W-1:0]     pix_q;

    always_comb begin
        font_bits = font_row(code, row);
        pix_d     = '0;
        if (valid) begin
            for (int b = 0; b < FONT_ROWS; b++) begin
                pix_d[b*GLYPH_SCALE +: GLYPH_SCALE] = {GLYPH_SCALE{font_bits[b]}};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) pix_q <= '0;
        else     pix_q <= pix_d;
    end

    assign char_pixels = pix_q;

endmodule

// File: rtl/board_char_store.sv
// Per-field display code store with a board-clear sequencer and a 2-cycle glyph line read path.
module board_char_store
    import board_char_pkg::*;
#(
    parameter int MAX_FIELDS  = 16,
    parameter int GLYPH_SCALE = 10
) (
    input  logic               clk,
    input  logic               rst,
    board_char_store_if.slave  bus
);

    localparam int ENTRIES = MAX_FIELDS * MAX_FIELDS;
    localparam int IDX_W   = $clog2(ENTRIES);
    localparam int LINES   = FONT_ROWS * GLYPH_SCALE;

    clear_state_t     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             clr_we;
    logic             usr_we;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [3:0]       mem_q [ENTRIES];
    logic [3:0]       rd_code_q;
    logic             valid_q, valid_d;
    logic [2:0]       row_q, row_d;

    // NOTE: every signal gets a default before the case so no path infers a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        clr_we  = 1'b0;
        usr_we  = 1'b0;
        wr_idx  = IDX_W'(int'(bus.wr_y) * MAX_FIELDS + int'(bus.wr_x));
        case (state_q)
            ST_CLEAR: begin
                clr_we = 1'b1;
                if (bus.clear_req) begin
                    idx_d = '0;
                end else if (idx_q == IDX_W'(ENTRIES - 1)) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                // A clear request in the same cycle as a write drops the write.
                if (bus.clear_req) begin
                    state_d = ST_CLEAR;
                    idx_d   = '0;
                end else begin
                    usr_we = bus.wr_en && !busy_q &&
                             (int'(bus.wr_x) < MAX_FIELDS) && (int'(bus.wr_y) < MAX_FIELDS);
                end
            end
        endcase
        busy_d = (state_d == ST_CLEAR);
    end

    // Row select is a comparator chain over the glyph lines rather than a divider.
    always_comb begin
        rd_idx = IDX_W'(int'(bus.char_y) * MAX_FIELDS + int'(bus.char_x));
        row_d  = '0;
        for (int k = FONT_ROWS - 1; k >= 0; k--) begin
            if (int'(bus.char_line) < (k + 1) * GLYPH_SCALE) row_d = 3'(k);
        end
        valid_d = (bus.char_x < bus.button_num) && (bus.char_y < bus.button_num) &&
                  (int'(bus.char_line) < LINES) && !busy_q;
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            row_q   <= row_d;
        end
    end

    // NOTE: storage has no reset; the clear sequencer that follows reset initialises it.
    always_ff @(posedge clk) begin
        if (clr_we)      mem_q[idx_q]  <= CODE_HIDDEN;
        else if (usr_we) mem_q[wr_idx] <= bus.wr_code;
        rd_code_q <= mem_q[rd_idx];
    end

    glyph_line_expand #(
        .GLYPH_SCALE (GLYPH_SCALE)
    ) u_expand (
        .clk         (clk),
        .rst         (rst),
        .code        (disp_code_t'(rd_code_q)),
        .row         (row_q),
        .valid       (valid_q),
        .char_pixels (bus.char_pixels)
    );

    assign bus.wr_ready = !busy_q;
    assign bus.busy     = busy_q;

endmodule
